// File: rtl/perceptron_trainer.sv
// Perceptron learning-rule trainer for a 2-input step neuron over a 4-entry truth table.
// Optional inference datapath enabled by PERCEPTRON_INFER_EN; otherwise infer_y is held at 0.
module perceptron_trainer #(
    parameter int W          = 8,
    parameter int LR         = 1,
    parameter int MAX_EPOCHS = 16,
    parameter int INIT_W     = 0,
    localparam int EW        = $clog2(MAX_EPOCHS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [3:0]          target,
    output logic                busy,
    output logic                done,
    output logic                converged,
    output logic [EW-1:0]       epoch_count,
    output logic signed [W-1:0] w1,
    output logic signed [W-1:0] w2,
    output logic signed [W-1:0] bias,
    input  logic                infer_a,
    input  logic                infer_b,
    output logic                infer_y
);
    typedef enum logic [1:0] {IDLE, TRAIN, CHECK, DONE} state_t;

    localparam logic signed [W-1:0] INIT_V = W'(INIT_W);
    localparam logic signed [W+1:0] S_MAX  = (W+2)'((2 ** (W-1)) - 1);
    localparam logic signed [W+1:0] S_MIN  = (W+2)'(-(2 ** (W-1)));
    localparam logic signed [W+1:0] STEP   = (W+2)'(LR);
    localparam logic signed [W+1:0] ZERO   = '0;

    function automatic logic signed [W+1:0] ext(input logic signed [W-1:0] v);
        return {{2{v[W-1]}}, v};
    endfunction

    function automatic logic fire(input logic a, input logic b,
                                  input logic signed [W-1:0] x1, input logic signed [W-1:0] x2,
                                  input logic signed [W-1:0] xb);
        logic signed [W+1:0] s;
        s = (a ? ext(x1) : ZERO) + (b ? ext(x2) : ZERO) + ext(xb);
        return s > ZERO;
    endfunction

    // W+2 bits leave headroom for any W-bit weight plus a step of up to 2^(W-1)-1.
    function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] v,
                                                     input logic signed [W+1:0] d);
        logic signed [W+1:0] s;
        s = ext(v) + d;
        if (s > S_MAX)      return S_MAX[W-1:0];
        else if (s < S_MIN) return S_MIN[W-1:0];
        else                return s[W-1:0];
    endfunction

    state_t                state_q, state_d;
    logic [3:0]            tgt_q, tgt_d;
    logic [1:0]            idx_q, idx_d;
    logic                  err_q, err_d;
    logic [EW-1:0]         epoch_q, epoch_d;
    logic signed [W-1:0]   w1_q, w1_d, w2_q, w2_d, b_q, b_d;
    logic                  busy_q, busy_d, done_q, done_d, conv_q, conv_d;
    logic                  infer_y_q, infer_y_d;

    logic                  pat_a, pat_b, pat_y, pat_t, miss;
    logic signed [W+1:0]   delta;

    always_comb begin
        pat_a = idx_q[1];
        pat_b = idx_q[0];
        pat_t = tgt_q[idx_q];
        pat_y = fire(pat_a, pat_b, w1_q, w2_q, b_q);
        miss  = pat_y != pat_t;
        delta = pat_t ? STEP : -STEP;

        state_d = state_q;
        tgt_d   = tgt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        epoch_d = epoch_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = done_q;
        conv_d  = conv_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = TRAIN;
                    tgt_d   = target;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    epoch_d = '0;
                    w1_d    = INIT_V;
                    w2_d    = INIT_V;
                    b_d     = INIT_V;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    conv_d  = 1'b0;
                end
            end
            TRAIN: begin
                if (miss) begin
                    if (pat_a) w1_d = sat_add(w1_q, delta);
                    if (pat_b) w2_d = sat_add(w2_q, delta);
                    b_d = sat_add(b_q, delta);
                end
                err_d = err_q | miss;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = CHECK;
            end
            CHECK: begin
                epoch_d = epoch_q + EW'(1);
                if (!err_q || epoch_d == EW'(MAX_EPOCHS)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    conv_d  = !err_q;
                end else begin
                    state_d = TRAIN;
                    err_d   = 1'b0;
                    idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PERCEPTRON_INFER_EN
    always_comb infer_y_d = fire(infer_a, infer_b, w1_q, w2_q, b_q);
`else
    logic unused_infer;
    assign unused_infer = infer_a ^ infer_b;
    always_comb infer_y_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tgt_q     <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            epoch_q   <= '0;
            w1_q      <= INIT_V;
            w2_q      <= INIT_V;
            b_q       <= INIT_V;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            conv_q    <= 1'b0;
            infer_y_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            epoch_q   <= epoch_d;
            w1_q      <= w1_d;
            w2_q      <= w2_d;
            b_q       <= b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            conv_q    <= conv_d;
            infer_y_q <= infer_y_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign converged   = conv_q;
    assign epoch_count = epoch_q;
    assign w1          = w1_q;
    assign w2          = w2_q;
    assign bias        = b_q;
    assign infer_y     = infer_y_q;
endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer: scoreboard of expected training results per start.
module tb_perceptron_trainer;
    logic              clk, rst_n, start, infer_a, infer_b;
    logic [3:0]        target;
    logic              busy, done, converged, infer_y;
    logic [4:0]        epoch_count;
    logic signed [7:0] w1, w2, bias;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string tag;
        int    w1, w2, b, ep, conv, cyc;
    } exp_t;
    exp_t sb[$];

    perceptron_trainer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .target(target),
        .busy(busy), .done(done), .converged(converged), .epoch_count(epoch_count),
        .w1(w1), .w2(w2), .bias(bias),
        .infer_a(infer_a), .infer_b(infer_b), .infer_y(infer_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    // Reference perceptron rule with LR=1, INIT_W=0, MAX_EPOCHS=16.
    function automatic exp_t model(input string tag, input logic [3:0] tgt);
        exp_t e;
        int a, b, s, d, ep;
        bit err, y;
        e.tag = tag; e.w1 = 0; e.w2 = 0; e.b = 0; e.conv = 0; ep = 0;
        while (ep < 16) begin
            err = 0;
            for (int i = 0; i < 4; i++) begin
                a = (i >> 1) & 1;
                b = i & 1;
                s = e.w1 * a + e.w2 * b + e.b;
                y = s > 0;
                if (y != tgt[i]) begin
                    err = 1;
                    d = tgt[i] ? 1 : -1;
                    e.w1 = clamp(e.w1 + d * a);
                    e.w2 = clamp(e.w2 + d * b);
                    e.b  = clamp(e.b + d);
                end
            end
            ep++;
            if (!err) begin
                e.conv = 1;
                break;
            end
        end
        e.ep = ep;
        e.cyc = 5 * ep;
        return e;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_conv"}, converged, 0);
        check({tag, "_epoch"}, epoch_count, 0);
        check({tag, "_w1"}, w1, 0);
        check({tag, "_w2"}, w2, 0);
        check({tag, "_bias"}, bias, 0);
        check({tag, "_infer_y"}, infer_y, 0);
    endtask

    // glitch_at: cycle during which start/target are disturbed; abort_at: cycle after which reset hits.
    task automatic train(input logic [3:0] tgt, input int glitch_at, input int abort_at,
                         input bit mid_chk);
        int cyc;
        bit seen;
        exp_t e;
        @(negedge clk);
        target = tgt;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        target = ~tgt;
        check("busy_rise", busy, 1);
        cyc = 0;
        seen = 0;
        while (cyc < 200 && !seen) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == glitch_at - 1) begin
                start  = 1'b1;
                target = 4'b0000;
            end
            if (cyc == glitch_at) start = 1'b0;
            if (mid_chk && cyc == 2) begin
                check("mid_w1", w1, 0);
                check("mid_w2", w2, 1);
                check("mid_bias", bias, 1);
            end
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_vals("abort");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (done) seen = 1;
            else check("busy_hold", busy, 1);
        end
        check("done_seen", seen, 1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "_cycles"}, cyc, e.cyc);
            check({e.tag, "_epochs"}, epoch_count, e.ep);
            check({e.tag, "_conv"}, converged, e.conv);
            check({e.tag, "_w1"}, w1, e.w1);
            check({e.tag, "_w2"}, w2, e.w2);
            check({e.tag, "_bias"}, bias, e.b);
            check({e.tag, "_busy_fall"}, busy, 0);
        end
    endtask

    task automatic infer(input logic a, input logic b, input logic exp);
        logic want;
        @(negedge clk);
        infer_a = a;
        infer_b = b;
        @(posedge clk);
        #1;
`ifdef PERCEPTRON_INFER_EN
        want = exp;
`else
        want = 1'b0;
`endif
        check("infer_y", infer_y, want);
        check("infer_done_hold", done, 1);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b1; start = 1'b0; target = 4'b0; infer_a = 1'b0; infer_b = 1'b0;
        #2 rst_n = 1'b0;
        #10;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        e = '{tag:"or", w1:1, w2:1, b:0, ep:4, conv:1, cyc:20};
        sb.push_back(e);
        train(4'b1110, 0, 0, 1'b1);
        infer(1'b1, 1'b0, 1'b1);
        infer(1'b0, 1'b0, 1'b0);

        e = '{tag:"and", w1:2, w2:1, b:-2, ep:6, conv:1, cyc:30};
        sb.push_back(e);
        train(4'b1000, 0, 0, 1'b0);
        infer(1'b0, 1'b0, 1'b0);
        infer(1'b0, 1'b1, 1'b0);
        infer(1'b1, 1'b0, 1'b0);
        infer(1'b1, 1'b1, 1'b1);

        e = model("xor", 4'b0110);
        e.ep = 16; e.conv = 0; e.cyc = 80;
        sb.push_back(e);
        train(4'b0110, 0, 0, 1'b0);

        e = '{tag:"or_glitch", w1:1, w2:1, b:0, ep:4, conv:1, cyc:20};
        sb.push_back(e);
        train(4'b1110, 7, 0, 1'b0);

        train(4'b1110, 0, 7, 1'b0);
        e = '{tag:"or_after_abort", w1:1, w2:1, b:0, ep:4, conv:1, cyc:20};
        sb.push_back(e);
        train(4'b1110, 0, 0, 1'b1);

        sb.push_back(model("nand", 4'b0111));
        train(4'b0111, 0, 0, 1'b0);
        infer(1'b1, 1'b1, 1'b0);
        infer(1'b0, 1'b1, 1'b1);

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
